// File: rtl/power_charge_pkg.sv
// Shared game definitions: charge FSM states, power width and default timing.
package power_charge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        READY,
        CHARGE,
        FIRE,
        FLIGHT
    } charge_state_t;

    localparam int unsigned POWER_W      = 4;
    localparam int unsigned CLK_HZ       = 60000000;
    localparam int unsigned RAMP_DIV     = CLK_HZ / 20;   // 20 Hz power steps
    localparam int unsigned DEBOUNCE_CYC = CLK_HZ / 100;  // 10 ms stable window

    // Counter width for a value range of n, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/power_charge_btn_debounce.sv
// Two-flop synchroniser plus stable-window debounce for a mechanical button.
module btn_debounce
    import power_charge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = power_charge_pkg::DEBOUNCE_CYC
) (
    input  logic clk60MHz,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = width_of(DEBOUNCE_CYC + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous level into the clock domain.
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for a full window; any bounce restarts it.
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (sync2 == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            cnt  <= '0;
            dout <= sync2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/power_charge.sv
// Turns the left-button level into a charged throw: triangle power ramp while held, fire on release.
module power_charge
    import power_charge_pkg::*;
#(
    parameter int unsigned RAMP_DIV     = power_charge_pkg::RAMP_DIV,
    parameter int unsigned DEBOUNCE_CYC = power_charge_pkg::DEBOUNCE_CYC,
    parameter int unsigned MIN_POWER    = 1,
    parameter int unsigned MAX_POWER    = 15
) (
    input  logic               clk60MHz,
    input  logic               rst,
    input  logic               left,
    input  logic               my_turn,
    input  logic               end_throw,
    output logic [POWER_W-1:0] power,
    output logic               charging,
    output logic               throw_start,
    output logic               busy
);

    localparam int unsigned PRE_W      = width_of(RAMP_DIV);
    localparam int unsigned SETTLE_CYC = DEBOUNCE_CYC + 2;
    localparam int unsigned SET_W      = width_of(SETTLE_CYC + 1);
    localparam logic [POWER_W-1:0] PMIN = POWER_W'(MIN_POWER);
    localparam logic [POWER_W-1:0] PMAX = POWER_W'(MAX_POWER);

    logic               btn;
    logic [SET_W-1:0]   settle_cnt;
    logic               settled;

    charge_state_t      state;
    charge_state_t      state_nx;
    logic [POWER_W-1:0] power_nx;
    logic [POWER_W-1:0] power_up;
    logic [POWER_W-1:0] power_dn;
    logic               dir_up;
    logic               dir_up_nx;
    logic [PRE_W-1:0]   presc;
    logic [PRE_W-1:0]   presc_nx;
    logic               charging_nx;
    logic               throw_start_nx;
    logic               busy_nx;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk60MHz(clk60MHz),
        .rst     (rst),
        .din     (left),
        .dout    (btn)
    );

    // btn is not meaningful until the synchroniser and debounce window have filled after reset,
    // so a button held through reset is seen as held (ARMED) rather than as a fresh press.
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end
    end

    assign settled  = (settle_cnt == SET_W'(SETTLE_CYC));
    assign power_up = power + POWER_W'(1);
    assign power_dn = power - POWER_W'(1);

    // State, ramp datapath and registered outputs.
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            power       <= PMIN;
            dir_up      <= 1'b1;
            presc       <= '0;
            charging    <= 1'b0;
            throw_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            power       <= power_nx;
            dir_up      <= dir_up_nx;
            presc       <= presc_nx;
            charging    <= charging_nx;
            throw_start <= throw_start_nx;
            busy        <= busy_nx;
        end
    end

    // Next-state, ramp stepping and output decode.
    always_comb begin
        state_nx  = state;
        power_nx  = power;
        dir_up_nx = dir_up;
        presc_nx  = presc;

        case (state)
            IDLE: begin
                if (my_turn && settled) begin
                    state_nx = btn ? ARMED : READY;
                end
            end
            ARMED: begin
                if (!btn) begin
                    state_nx = READY;
                end
            end
            READY: begin
                if (!my_turn) begin
                    state_nx = IDLE;
                end else if (btn) begin
                    state_nx  = CHARGE;
                    power_nx  = PMIN;
                    dir_up_nx = 1'b1;
                    presc_nx  = '0;
                end
            end
            CHARGE: begin
                if (!my_turn) begin
                    state_nx = IDLE;
                    power_nx = PMIN;
                end else if (!btn) begin
                    // Release beats a coincident prescaler wrap: power freezes as is.
                    state_nx = FIRE;
                end else if (presc == PRE_W'(RAMP_DIV - 1)) begin
                    presc_nx = '0;
                    if (dir_up) begin
                        power_nx = power_up;
                        if (power_up == PMAX) begin
                            dir_up_nx = 1'b0;
                        end
                    end else begin
                        power_nx = power_dn;
                        if (power_dn == PMIN) begin
                            dir_up_nx = 1'b1;
                        end
                    end
                end else begin
                    presc_nx = presc + PRE_W'(1);
                end
            end
            FIRE: begin
                state_nx = FLIGHT;
            end
            FLIGHT: begin
                if (end_throw) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        charging_nx    = (state_nx == CHARGE);
        throw_start_nx = (state_nx == FIRE);
        busy_nx        = (state_nx == FIRE) || (state_nx == FLIGHT);
    end

endmodule

// File: tb/tb_power_charge.sv
// Scoreboard bench for power_charge: stimulus queues expected throws, a monitor checks each pulse.
module tb_power_charge;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       left = 1'b0;
    logic       my_turn = 1'b0;
    logic       end_throw = 1'b0;
    logic [3:0] power;
    logic       charging;
    logic       throw_start;
    logic       busy;

    typedef struct {
        int pwr;
        int at;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   range_errs = 0;

    power_charge #(
        .RAMP_DIV    (4),
        .DEBOUNCE_CYC(3),
        .MIN_POWER   (1),
        .MAX_POWER   (15)
    ) dut (
        .clk60MHz   (clk),
        .rst        (rst),
        .left       (left),
        .my_turn    (my_turn),
        .end_throw  (end_throw),
        .power      (power),
        .charging   (charging),
        .throw_start(throw_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every throw_start pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (power < 4'd1 || power > 4'd15) range_errs++;
            if (throw_start) begin
                check("throw_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    check("throw_power", int'(power), cur.pwr);
                    check("throw_busy", int'(busy), 1);
                    check("throw_cycle", cyc, cur.at);
                end
            end
        end
    end

    // Press the button and wait (bounded) for the DUT to enter CHARGE.
    task automatic press();
        int ok;
        ok = 0;
        left = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (charging) begin
                ok = 1;
                break;
            end
        end
        check("charge_entered", ok, 1);
    endtask

    // Hold m cycles after CHARGE entry, release, expect a throw 6 edges later.
    task automatic throw_once(input int m, input int exp_pwr);
        press();
        repeat (m) @(posedge clk);
        #1 left = 1'b0;
        exp_q.push_back('{exp_pwr, cyc + 6});
        repeat (12) @(posedge clk);
        #1;
        check("throw_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Land the projectile and expect busy to drop on the accepting edge.
    task automatic finish_throw();
        end_throw = 1'b1;
        @(posedge clk);
        #1 end_throw = 1'b0;
        @(negedge clk);
        check("end_throw_busy", int'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        // Reset with the button held and our turn active.
        rst = 1'b0;
        left = 1'b1;
        my_turn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_power", int'(power), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_charging", int'(charging), 0);
        check("rst_throw_start", int'(throw_start), 0);
        rst = 1'b1;

        // Button carried over from reset must not charge.
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (charging) cnt++;
        end
        check("armed_no_charge", cnt, 0);
        @(posedge clk);
        #1 left = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Short press: two ramp ticks, then power must hold through the flight.
        throw_once(3, 3);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("hold_power", int'(power), 3);
        check("hold_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        finish_throw();

        // Triangle: 20 ticks peak at 15 and fall to 9; 19 ticks with release on a wrap gives 10.
        throw_once(75, 9);
        finish_throw();
        throw_once(74, 10);
        finish_throw();

        // Bounce: toggling every two cycles never clears the debounce window.
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            left = ((i % 4) < 2);
            @(posedge clk);
            #1;
            if (charging) cnt++;
        end
        left = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (charging) cnt++;
        end
        check("bounce_no_charge", cnt, 0);

        // Aborted charge: losing the turn drops to IDLE with MIN power and no pulse.
        press();
        repeat (6) @(posedge clk);
        #1 my_turn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_charging", int'(charging), 0);
        check("abort_power", int'(power), 1);
        repeat (10) @(posedge clk);
        #1 my_turn = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (charging) cnt++;
        end
        check("rearm_no_charge", cnt, 0);
        @(posedge clk);
        #1 left = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Events in flight: my_turn toggles are ignored, reset clears busy at once.
        throw_once(3, 3);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            my_turn = ~my_turn;
            @(posedge clk);
            #1;
            if (!busy) cnt++;
        end
        my_turn = 1'b1;
        check("flight_busy_held", cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_flight_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        check("queue_empty", exp_q.size(), 0);
        check("power_range", range_errs, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
